// File: rtl/ascii_up_counter_if.sv
// ascii_up_counter_if: load handshake, increment and count/status bundle for ascii_up_counter
interface ascii_up_counter_if;
  logic        load_valid;
  logic [15:0] load_ascii;
  logic        load_ready;
  logic        increment;
  logic [15:0] counter;
  logic        done;
  logic        error;
  modport master (output load_valid, load_ascii, increment, input load_ready, counter, done, error);
  modport slave (input load_valid, load_ascii, increment, output load_ready, counter, done, error);
endinterface

// File: rtl/ascii_up_counter.sv
// ascii_up_counter: two-digit ASCII up-counter with validated load; wrap mode via ASCII_CNT_WRAP_EN (clock, reset active-low async, bus: load_valid/load_ascii/load_ready/increment/counter/done/error)
module ascii_up_counter #(
  parameter logic [15:0] LIMIT = "99"
) (
  input logic clock,
  input logic reset,
  ascii_up_counter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, COUNT, DONE, ERR} state_t;
  state_t state;
  logic [15:0] hold;
  logic hold_ok;
  logic [15:0] next_count;
  function automatic logic is_digit(input logic [7:0] b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction
  // Two valid ASCII digits compare in the same order as their decimal values.
  assign hold_ok = is_digit(hold[15:8]) && is_digit(hold[7:0]) && hold <= LIMIT;
  assign next_count = bus.counter[7:0] != "9" ? {bus.counter[15:8], bus.counter[7:0] + 8'd1}
                                              : {bus.counter[15:8] + 8'd1, 8'h30};
  assign bus.load_ready = state != CHECK;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      hold        <= '0;
      bus.counter <= "--";
      bus.done    <= 1'b0;
      bus.error   <= 1'b0;
    end else if (bus.load_valid && bus.load_ready) begin
      state     <= CHECK;
      hold      <= bus.load_ascii;
      bus.done  <= 1'b0;
      bus.error <= 1'b0;
    end else begin
      case (state)
        CHECK: begin
          state       <= hold_ok ? COUNT : ERR;
          bus.counter <= hold_ok ? hold : "ER";
          bus.error   <= !hold_ok;
        end
        COUNT: begin
          bus.done <= 1'b0;
          if (bus.increment) begin
            if (bus.counter == LIMIT) begin
`ifdef ASCII_CNT_WRAP_EN
              bus.counter <= "00";
              bus.done    <= 1'b1;
`else
              bus.counter <= "OV";
              bus.done    <= 1'b1;
              state       <= DONE;
`endif
            end else begin
              bus.counter <= next_count;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ascii_up_counter.sv
// tb_ascii_up_counter: table-driven and directed checks of ascii_up_counter at LIMIT "99" and "25"
module tb_ascii_up_counter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
`ifdef ASCII_CNT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  ascii_up_counter_if bus ();
  ascii_up_counter_if bus25 ();
  ascii_up_counter #(.LIMIT("99")) dut (.clock(clock), .reset(reset), .bus(bus));
  ascii_up_counter #(.LIMIT("25")) dut25 (.clock(clock), .reset(reset), .bus(bus25));
  always #5 clock = ~clock;
  typedef struct {
    logic        lv;
    logic [15:0] la;
    logic        inc;
    logic [15:0] cnt;
    logic        done;
    logic        err;
    logic        rdy;
  } vec_t;
  vec_t v[$];
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk_main(input string n, input logic [15:0] c, input logic d, input logic e, input logic r);
    chk({n, ".counter"}, bus.counter, c);
    chk({n, ".done"}, {15'd0, bus.done}, {15'd0, d});
    chk({n, ".error"}, {15'd0, bus.error}, {15'd0, e});
    chk({n, ".ready"}, {15'd0, bus.load_ready}, {15'd0, r});
  endtask
  task automatic chk_25(input string n, input logic [15:0] c, input logic d, input logic e);
    chk({n, ".counter"}, bus25.counter, c);
    chk({n, ".done"}, {15'd0, bus25.done}, {15'd0, d});
    chk({n, ".error"}, {15'd0, bus25.error}, {15'd0, e});
  endtask
  initial begin
    bus.load_valid = 0; bus.load_ascii = '0; bus.increment = 0;
    bus25.load_valid = 0; bus25.load_ascii = '0; bus25.increment = 0;
    v.push_back('{1, "18", 0, "--", 0, 0, 0});
    v.push_back('{0, 0, 0, "18", 0, 0, 1});
    v.push_back('{0, 0, 1, "19", 0, 0, 1});
    v.push_back('{0, 0, 1, "20", 0, 0, 1});
    v.push_back('{0, 0, 1, "21", 0, 0, 1});
    v.push_back('{0, 0, 0, "21", 0, 0, 1});
    v.push_back('{1, "1A", 0, "21", 0, 0, 0});
    v.push_back('{0, 0, 1, "ER", 0, 1, 1});
    v.push_back('{0, 0, 1, "ER", 0, 1, 1});
    v.push_back('{1, "05", 1, "ER", 0, 0, 0});
    v.push_back('{0, 0, 0, "05", 0, 0, 1});
    v.push_back('{1, "99", 0, "05", 0, 0, 0});
    v.push_back('{0, 0, 0, "99", 0, 0, 1});
    v.push_back('{1, "42", 0, "99", 0, 0, 0});
    v.push_back('{0, 0, 0, "42", 0, 0, 1});
    v.push_back('{1, "07", 1, "42", 0, 0, 0});
    v.push_back('{0, 0, 0, "07", 0, 0, 1});
    v.push_back('{1, "9:", 0, "07", 0, 0, 0});
    v.push_back('{0, 0, 0, "ER", 0, 1, 1});
    v.push_back('{1, "/5", 0, "ER", 0, 0, 0});
    v.push_back('{0, 0, 0, "ER", 0, 1, 1});
    v.push_back('{1, "09", 0, "ER", 0, 0, 0});
    v.push_back('{0, 0, 1, "09", 0, 0, 1});
    v.push_back('{0, 0, 1, "10", 0, 0, 1});
    tick();
    chk_main("reset", "--", 0, 0, 1);
    reset = 1;
    bus.increment = 1;
    tick();
    chk_main("idle_inc", "--", 0, 0, 1);
    bus.increment = 0;
    for (int i = 0; i < v.size(); i++) begin
      bus.load_valid = v[i].lv; bus.load_ascii = v[i].la; bus.increment = v[i].inc;
      tick();
      chk_main($sformatf("vec%0d", i), v[i].cnt, v[i].done, v[i].err, v[i].rdy);
    end
    bus.load_valid = 1; bus.load_ascii = "98"; bus.increment = 0;
    tick();
    bus.load_valid = 0;
    tick();
    chk_main("load98", "98", 0, 0, 1);
    bus.increment = 1;
    tick();
    chk_main("inc99", "99", 0, 0, 1);
    tick();
    chk_main("at_limit", WRAP ? 16'h3030 : 16'h4F56, 1, 0, 1);
    bus.increment = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_main($sformatf("hold%0d", i), WRAP ? 16'h3030 : 16'h4F56, !WRAP, 0, 1);
    end
    bus.increment = 1;
    tick();
    chk_main("post_limit_inc", WRAP ? 16'h3031 : 16'h4F56, !WRAP, 0, 1);
    bus.increment = 0;
    bus.load_valid = 1; bus.load_ascii = "33";
    tick();
    bus.load_valid = 0;
    chk_main("pre_reset_check", WRAP ? 16'h3031 : 16'h4F56, 0, 0, 0);
    reset = 0;
    #1;
    chk_main("async_reset", "--", 0, 0, 1);
    tick();
    reset = 1;
    tick();
    chk_main("after_reset", "--", 0, 0, 1);
    bus25.load_valid = 1; bus25.load_ascii = "30";
    tick();
    bus25.load_valid = 0;
    tick();
    chk_25("l25_30", "ER", 0, 1);
    bus25.load_valid = 1; bus25.load_ascii = "24"; bus25.increment = 1;
    tick();
    bus25.load_valid = 0;
    chk_25("l25_check", "ER", 0, 0);
    tick();
    chk_25("l25_24", "24", 0, 0);
    tick();
    chk_25("l25_25", "25", 0, 0);
    tick();
    chk_25("l25_limit", WRAP ? 16'h3030 : 16'h4F56, 1, 0);
    tick();
    chk_25("l25_after", WRAP ? 16'h3031 : 16'h4F56, !WRAP, 0);
    bus25.increment = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
